// File: rtl/lsu_mem_initiator_pkg.sv
// Shared types and constants for the LSU memory initiator.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2,
    RESP    = 2'd3
  } lsu_state_e;

  localparam logic [1:0] SZ_B      = 2'd0;
  localparam logic [1:0] SZ_H      = 2'd1;
  localparam logic [1:0] SZ_W      = 2'd2;
  localparam logic [1:0] RESP_OKAY = 2'b00;

  // Size code 3 is treated as a word access.
  function automatic logic is_misaligned(input logic [1:0] off, input logic [1:0] size);
    logic r;
    r = 1'b0;
    if (size == SZ_H)
      r = off[0];
    else if (size[1])
      r = (off != 2'b00);
    return r;
  endfunction

endpackage

// File: rtl/lsu_mem_initiator_if.sv
// Core-side request/response bus and SRAM-side ren/wen bus of the LSU initiator.
interface lsu_core_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_wen;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic                  resp_valid;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  resp_err;

  modport master (
    output req_valid, req_wen, req_addr, req_wdata, req_size, req_unsigned,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_wen, req_addr, req_wdata, req_size, req_unsigned,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

interface lsu_mem_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    ren;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [DATA_WIDTH-1:0]   wdata;
  logic                    wen;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic [1:0]              bresp;
  logic                    bvalid;

  modport master (
    output araddr, ren, awaddr, wdata, wen, wstrb,
    input  rdata, rresp, rvalid, bresp, bvalid
  );

  modport slave (
    input  araddr, ren, awaddr, wdata, wen, wstrb,
    output rdata, rresp, rvalid, bresp, bvalid
  );
endinterface

// File: rtl/lsu_mem_initiator_data_align.sv
// Byte-lane alignment: store strobe/data shift and load lane extract + extend.
module lsu_data_align
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [1:0]              i_off,
  input  logic [1:0]              i_size,
  input  logic                    i_unsigned,
  input  logic [DATA_WIDTH-1:0]   i_wdata,
  input  logic [DATA_WIDTH-1:0]   i_rdata,
  output logic [DATA_WIDTH/8-1:0] o_wstrb,
  output logic [DATA_WIDTH-1:0]   o_wdata,
  output logic [DATA_WIDTH-1:0]   o_rdata
);
  logic [DATA_WIDTH/8-1:0] w_mask;
  logic [DATA_WIDTH-1:0]   w_lane;
  logic [4:0]              w_shamt;

  assign w_shamt = {i_off, 3'b000};

  always_comb begin
    w_mask = '1;
    if (i_size == SZ_B)      w_mask = 4'b0001;
    else if (i_size == SZ_H) w_mask = 4'b0011;
  end

  // Lanes shifted past byte 3 fall off the top: misaligned accesses truncate.
  assign o_wstrb = w_mask << i_off;
  assign o_wdata = i_wdata << w_shamt;
  assign w_lane  = i_rdata >> w_shamt;

  always_comb begin
    o_rdata = w_lane;
    if (i_size == SZ_B)
      o_rdata = {{(DATA_WIDTH-8){~i_unsigned & w_lane[7]}}, w_lane[7:0]};
    else if (i_size == SZ_H)
      o_rdata = {{(DATA_WIDTH-16){~i_unsigned & w_lane[15]}}, w_lane[15:0]};
  end
endmodule

// File: rtl/lsu_mem_initiator.sv
// LSU initiator for the ren/wen SRAM handshake: one outstanding load/store.
// Optional build macro LSU_MISALIGN_CHECK_EN rejects misaligned half/word accesses.
module lsu_mem_initiator
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic      clk,
  input  logic      rst,
  lsu_core_if.slave core,
  lsu_mem_if.master mem
);
  lsu_state_e r_state, w_next;

  logic                    r_wen;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [1:0]              r_size;
  logic                    r_unsigned;
  logic [DATA_WIDTH-1:0]   r_resp_rdata;
  logic                    r_resp_err;

  logic                    w_accept, w_misalign;
  logic                    w_ren, w_wen, w_req_ready, w_resp_valid;
  logic [DATA_WIDTH/8-1:0] w_wstrb;
  logic [DATA_WIDTH-1:0]   w_wdata, w_ld_data;

`ifdef LSU_MISALIGN_CHECK_EN
  assign w_misalign = is_misaligned(core.req_addr[1:0], core.req_size);
`else
  assign w_misalign = 1'b0;
`endif

  assign w_accept = core.req_valid && (r_state == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    w_ren        = 1'b0;
    w_wen        = 1'b0;
    w_req_ready  = 1'b0;
    w_resp_valid = 1'b0;
    case (r_state)
      IDLE: begin
        w_req_ready = 1'b1;
        if (w_accept) begin
          if (w_misalign)        w_next = RESP;
          else if (core.req_wen) w_next = WR_WAIT;
          else                   w_next = RD_WAIT;
        end
      end
      RD_WAIT: begin
        w_ren = 1'b1;
        if (mem.rvalid) w_next = RESP;
      end
      WR_WAIT: begin
        w_wen = 1'b1;
        if (mem.bvalid) w_next = RESP;
      end
      // Gap cycle so the responder can drop a valid before the next request.
      RESP: begin
        w_resp_valid = 1'b1;
        w_next       = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wen        <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_size       <= SZ_B;
      r_unsigned   <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_wen      <= core.req_wen;
        r_addr     <= core.req_addr;
        r_wdata    <= core.req_wdata;
        r_size     <= core.req_size;
        r_unsigned <= core.req_unsigned;
        if (w_misalign) begin
          r_resp_rdata <= '0;
          r_resp_err   <= 1'b1;
        end
      end
      if (r_state == RD_WAIT && mem.rvalid) begin
        r_resp_rdata <= w_ld_data;
        r_resp_err   <= (mem.rresp != RESP_OKAY);
      end
      if (r_state == WR_WAIT && mem.bvalid) begin
        r_resp_rdata <= '0;
        r_resp_err   <= (mem.bresp != RESP_OKAY);
      end
    end
  end

  lsu_data_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .i_off      (r_addr[1:0]),
    .i_size     (r_size),
    .i_unsigned (r_unsigned),
    .i_wdata    (r_wdata),
    .i_rdata    (mem.rdata),
    .o_wstrb    (w_wstrb),
    .o_wdata    (w_wdata),
    .o_rdata    (w_ld_data)
  );

  // Memory-side outputs come only from registers, so they hold steady during a wait.
  assign mem.araddr = {r_addr[ADDR_WIDTH-1:2], 2'b00};
  assign mem.awaddr = {r_addr[ADDR_WIDTH-1:2], 2'b00};
  assign mem.wdata  = w_wdata;
  assign mem.wstrb  = r_wen ? w_wstrb : '0;
  assign mem.ren    = w_ren;
  assign mem.wen    = w_wen;

  assign core.req_ready  = w_req_ready;
  assign core.resp_valid = w_resp_valid;
  assign core.resp_rdata = r_resp_rdata;
  assign core.resp_err   = r_resp_err;
endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Directed bench for lsu_mem_initiator with a response scoreboard.
module tb_lsu_mem_initiator;
  import lsu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lsu_core_if core ();
  lsu_mem_if  mem ();

  lsu_mem_initiator dut (
    .clk  (clk),
    .rst  (rst),
    .core (core),
    .mem  (mem)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] rd, input logic err);
    exp_t e;
    e.rdata = rd;
    e.err   = err;
    sb.push_back(e);
  endtask

  task automatic check_resp(input string tag);
    exp_t e;
    chk({tag, "_valid"}, {31'd0, core.resp_valid}, 32'd1);
    chk({tag, "_pending"}, {31'd0, sb.size() != 0}, 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_rdata"}, core.resp_rdata, e.rdata);
      chk({tag, "_err"}, {31'd0, core.resp_err}, {31'd0, e.err});
    end
  endtask

  task automatic issue(input logic wen, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [1:0] size, input logic uns);
    chk("req_ready_idle", {31'd0, core.req_ready}, 32'd1);
    core.req_wen      = wen;
    core.req_addr     = addr;
    core.req_wdata    = wd;
    core.req_size     = size;
    core.req_unsigned = uns;
    core.req_valid    = 1'b1;
    tick();
    core.req_valid    = 1'b0;
  endtask

  task automatic do_load(input string tag, input logic [31:0] addr, input logic [1:0] size,
                         input logic uns, input logic [31:0] rd, input logic [1:0] rresp,
                         input logic [31:0] exp_rd, input logic [31:0] exp_araddr);
    issue(1'b0, addr, 32'h0, size, uns);
    push(exp_rd, rresp != RESP_OKAY);
    chk({tag, "_ren"}, {31'd0, mem.ren}, 32'd1);
    chk({tag, "_wen"}, {31'd0, mem.wen}, 32'd0);
    chk({tag, "_araddr"}, mem.araddr, exp_araddr);
    tick();
    chk({tag, "_ren_hold"}, {31'd0, mem.ren}, 32'd1);
    mem.rdata  = rd;
    mem.rresp  = rresp;
    mem.rvalid = 1'b1;
    tick();
    mem.rvalid = 1'b0;
    check_resp(tag);
    chk({tag, "_ren_drop"}, {31'd0, mem.ren}, 32'd0);
    tick();
    chk({tag, "_pulse"}, {31'd0, core.resp_valid}, 32'd0);
  endtask

  task automatic do_store(input string tag, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [1:0] size, input logic [31:0] exp_awaddr,
                          input logic [3:0] exp_strb, input logic [31:0] exp_wdata);
    issue(1'b1, addr, wd, size, 1'b0);
    push(32'h0, 1'b0);
    chk({tag, "_wen"}, {31'd0, mem.wen}, 32'd1);
    chk({tag, "_ren"}, {31'd0, mem.ren}, 32'd0);
    chk({tag, "_awaddr"}, mem.awaddr, exp_awaddr);
    chk({tag, "_wstrb"}, {28'd0, mem.wstrb}, {28'd0, exp_strb});
    chk({tag, "_wdata"}, mem.wdata, exp_wdata);
    repeat (2) begin
      tick();
      chk({tag, "_wen_hold"}, {31'd0, mem.wen}, 32'd1);
      chk({tag, "_no_early"}, {31'd0, core.resp_valid}, 32'd0);
    end
    mem.bresp  = RESP_OKAY;
    mem.bvalid = 1'b1;
    tick();
    mem.bvalid = 1'b0;
    check_resp(tag);
    chk({tag, "_wen_drop"}, {31'd0, mem.wen}, 32'd0);
    tick();
    chk({tag, "_pulse"}, {31'd0, core.resp_valid}, 32'd0);
  endtask

  initial begin
    core.req_valid = 1'b0; core.req_wen = 1'b0; core.req_addr = '0;
    core.req_wdata = '0; core.req_size = SZ_B; core.req_unsigned = 1'b0;
    mem.rdata = '0; mem.rresp = '0; mem.rvalid = 1'b0;
    mem.bresp = '0; mem.bvalid = 1'b0;

    repeat (2) tick();
    chk("rst_ren", {31'd0, mem.ren}, 32'd0);
    chk("rst_wen", {31'd0, mem.wen}, 32'd0);
    chk("rst_resp_valid", {31'd0, core.resp_valid}, 32'd0);
    chk("rst_resp_rdata", core.resp_rdata, 32'd0);
    chk("rst_resp_err", {31'd0, core.resp_err}, 32'd0);
    chk("rst_araddr", mem.araddr, 32'd0);
    chk("rst_awaddr", mem.awaddr, 32'd0);
    chk("rst_wdata", mem.wdata, 32'd0);
    chk("rst_wstrb", {28'd0, mem.wstrb}, 32'd0);
    rst = 1'b0;
    tick();

    do_store("st_word", 32'h8000_0004, 32'hDEAD_BEEF, SZ_W, 32'h8000_0004, 4'hF, 32'hDEAD_BEEF);
    do_load("ld_b_s", 32'h8000_0003, SZ_B, 1'b0, 32'h8011_2233, 2'b00, 32'hFFFF_FF80, 32'h8000_0000);
    do_load("ld_b_u", 32'h8000_0003, SZ_B, 1'b1, 32'h8011_2233, 2'b00, 32'h0000_0080, 32'h8000_0000);
    do_store("st_half", 32'h8000_0002, 32'h0000_ABCD, SZ_H, 32'h8000_0000, 4'b1100, 32'hABCD_0000);
    do_store("st_byte", 32'h8000_0001, 32'h0000_00AB, SZ_B, 32'h8000_0000, 4'b0010, 32'h0000_AB00);
    do_load("ld_h_s", 32'h8000_0000, SZ_H, 1'b0, 32'h0001_8765, 2'b00, 32'hFFFF_8765, 32'h8000_0000);
    do_load("ld_err", 32'h8000_0002, SZ_H, 1'b1, 32'hFFEE_1234, 2'b10, 32'h0000_FFEE, 32'h8000_0000);

    // Store then load back-to-back, with bvalid left high through RESP and IDLE.
    issue(1'b1, 32'h8000_0008, 32'h1234_5678, SZ_W, 1'b0);
    push(32'h0, 1'b0);
    tick();
    mem.bresp = RESP_OKAY;
    mem.bvalid = 1'b1;
    tick();
    check_resp("b2b_st");
    core.req_wen = 1'b0; core.req_addr = 32'h8000_000C; core.req_size = SZ_W;
    core.req_unsigned = 1'b0; core.req_valid = 1'b1;
    push(32'h1122_3344, 1'b0);
    chk("b2b_ready_resp", {31'd0, core.req_ready}, 32'd0);
    tick();
    chk("b2b_ready_idle", {31'd0, core.req_ready}, 32'd1);
    chk("b2b_no_resp_idle", {31'd0, core.resp_valid}, 32'd0);
    chk("b2b_ren_idle", {31'd0, mem.ren}, 32'd0);
    tick();
    core.req_valid = 1'b0;
    mem.bvalid = 1'b0;
    chk("b2b_ren", {31'd0, mem.ren}, 32'd1);
    chk("b2b_wen", {31'd0, mem.wen}, 32'd0);
    chk("b2b_no_early", {31'd0, core.resp_valid}, 32'd0);
    chk("b2b_araddr", mem.araddr, 32'h8000_000C);
    tick();
    chk("b2b_no_early2", {31'd0, core.resp_valid}, 32'd0);
    mem.rdata = 32'h1122_3344; mem.rresp = 2'b00; mem.rvalid = 1'b1;
    tick();
    check_resp("b2b_ld");
    tick();
    mem.rvalid = 1'b0;
    chk("b2b_resp_pulse", {31'd0, core.resp_valid}, 32'd0);
    chk("b2b_ready_after", {31'd0, core.req_ready}, 32'd1);
    chk("resp_rdata_hold", core.resp_rdata, 32'h1122_3344);
    tick();

    // Reset while a load waits: abort without a response.
    issue(1'b0, 32'h8000_0010, 32'h0, SZ_W, 1'b0);
    chk("abort_ren_before", {31'd0, mem.ren}, 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_ren", {31'd0, mem.ren}, 32'd0);
    chk("abort_no_resp", {31'd0, core.resp_valid}, 32'd0);
    tick();
    rst = 1'b0;
    mem.rvalid = 1'b1;
    mem.rdata = 32'hCAFE_F00D;
    tick();
    chk("abort_stale_valid", {31'd0, core.resp_valid}, 32'd0);
    chk("abort_ready", {31'd0, core.req_ready}, 32'd1);
    mem.rvalid = 1'b0;
    tick();

`ifdef LSU_MISALIGN_CHECK_EN
    issue(1'b0, 32'h8000_0001, 32'h0, SZ_W, 1'b0);
    push(32'h0, 1'b1);
    chk("mis_ren", {31'd0, mem.ren}, 32'd0);
    check_resp("mis_ld");
    tick();
    chk("mis_ren_after", {31'd0, mem.ren}, 32'd0);
    chk("mis_ready", {31'd0, core.req_ready}, 32'd1);
    issue(1'b1, 32'h8000_0003, 32'h0000_1234, SZ_H, 1'b0);
    push(32'h0, 1'b1);
    chk("mis_wen", {31'd0, mem.wen}, 32'd0);
    check_resp("mis_st");
    tick();
`else
    do_load("mis_ld", 32'h8000_0001, SZ_W, 1'b0, 32'hAABB_CCDD, 2'b00, 32'h00AA_BBCC, 32'h8000_0000);
    do_store("mis_st", 32'h8000_0003, 32'h0000_1234, SZ_H, 32'h8000_0000, 4'b1000, 32'h3400_0000);
`endif

    chk("sb_drained", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
